// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access sequencer.
// Takes a load/store from the EX/MEM register and runs it on a req/ack bus.
// It builds the byte enables, lane-replicates the store data, and
// sign- or zero-extends the load data. The pipeline is stalled until the
// access completes. Misaligned requests and bus timeouts raise one-cycle
// exception pulses.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-low reset
//   mem_read_in/mem_write_in  load/store request (both set => store)
//   size_in, unsigned_in      access size (00 B, 01 H, 1x W), zero-extend loads
//   addr_in, wdata_in         byte address, store data
//   bus_*                     req/ack data bus (registered outputs)
//   stall_out                 freezes IF/ID/EX/MEM while the access is open
//   rdata_out/rdata_valid_out extended load result and its one-cycle valid
//   misalign_out/timeout_out  exception pulses
module mem_access_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [1:0]       size_in,
    input  logic             unsigned_in,
    input  logic [WIDTH-1:0] addr_in,
    input  logic [WIDTH-1:0] wdata_in,
    output logic             bus_req_out,
    output logic             bus_we_out,
    output logic [WIDTH-1:0] bus_addr_out,
    output logic [3:0]       bus_be_out,
    output logic [WIDTH-1:0] bus_wdata_out,
    input  logic             bus_ack_in,
    input  logic [WIDTH-1:0] bus_rdata_in,
    output logic             stall_out,
    output logic [WIDTH-1:0] rdata_out,
    output logic             rdata_valid_out,
    output logic             misalign_out,
    output logic             timeout_out
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic [1:0]      lane_r;
    logic [1:0]      size_r;
    logic            unsigned_r;
    logic            req_s, aligned_s, accept_s, tmo_s, stall_s;
    logic            misalign_r, rdata_valid_r, timeout_r, bus_we_r;
    logic [3:0]      bus_be_r;
    logic [WIDTH-1:0] bus_addr_r, bus_wdata_r, rdata_r;

    // Byte enables for a size/offset pair; size 11 behaves as a word.
    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   calc_be = 4'b0001 << lo;
            2'b01:   calc_be = lo[1] ? 4'b1100 : 4'b0011;
            default: calc_be = 4'b1111;
        endcase
    endfunction

    // Replicate the store operand so that every enabled lane sees it.
    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   calc_wdata = {4{wd[7:0]}};
            2'b01:   calc_wdata = {2{wd[15:0]}};
            default: calc_wdata = wd;
        endcase
    endfunction

    // Select the addressed lane of the bus word and extend it to 32 bits.
    function automatic logic [31:0] extend(input logic [1:0] size, input logic uns,
                                           input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] shifted;
        logic [15:0] half;
        shifted = rd >> {lo, 3'b000};
        half    = lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   extend = {{24{shifted[7] & ~uns}}, shifted[7:0]};
            2'b01:   extend = {{16{half[15] & ~uns}}, half};
            default: extend = rd;
        endcase
    endfunction

    assign req_s = mem_read_in | mem_write_in;

    // Alignment check for the request that is currently presented.
    always_comb begin
        case (size_in)
            2'b00:   aligned_s = 1'b1;
            2'b01:   aligned_s = ~addr_in[0];
            default: aligned_s = (addr_in[1:0] == 2'b00);
        endcase
    end

    // Next-state and stall decode.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        tmo_s    = 1'b0;
        stall_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s && aligned_s) begin
                    accept_s = 1'b1;
                    stall_s  = 1'b1;
                    state_s  = ACCESS;
                end else begin
                    state_s  = IDLE;
                end
            end
            ACCESS: begin
                stall_s = 1'b1;
                // A same-cycle ack takes priority over the expiring counter.
                if (bus_ack_in) begin
                    state_s = RESP;
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    tmo_s   = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = ACCESS;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Access context, cycle counter, read-data latch and exception pulses.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_r         <= '0;
            lane_r        <= 2'b00;
            size_r        <= 2'b00;
            unsigned_r    <= 1'b0;
            bus_we_r      <= 1'b0;
            bus_be_r      <= 4'b0000;
            bus_addr_r    <= '0;
            bus_wdata_r   <= '0;
            rdata_r       <= '0;
            misalign_r    <= 1'b0;
            rdata_valid_r <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            misalign_r    <= (state_r == IDLE) && req_s && !aligned_s;
            rdata_valid_r <= (state_r == ACCESS) && bus_ack_in && !bus_we_r;
            timeout_r     <= tmo_s;
            if (accept_s) begin
                cnt_r       <= '0;
                lane_r      <= addr_in[1:0];
                size_r      <= size_in;
                unsigned_r  <= unsigned_in;
                bus_we_r    <= mem_write_in;
                bus_be_r    <= calc_be(size_in, addr_in[1:0]);
                bus_addr_r  <= {addr_in[WIDTH-1:2], 2'b00};
                bus_wdata_r <= calc_wdata(size_in, wdata_in);
            end else if (state_r == ACCESS) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r == ACCESS) && bus_ack_in && !bus_we_r) begin
                rdata_r <= extend(size_r, unsigned_r, lane_r, bus_rdata_in);
            end else if (tmo_s) begin
                rdata_r <= '0;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus_req_out     = (state_r == ACCESS);
    assign bus_we_out      = bus_we_r;
    assign bus_be_out      = bus_be_r;
    assign bus_addr_out    = bus_addr_r;
    assign bus_wdata_out   = bus_wdata_r;
    assign rdata_out       = rdata_r;
    assign rdata_valid_out = rdata_valid_r;
    assign misalign_out    = misalign_r;
    assign timeout_out     = timeout_r;
    // The issue-cycle stall is combinational. Gating it with the reset keeps
    // the pipeline released while reset is held, even if a request is still
    // being presented.
    assign stall_out       = stall_s & rst_in;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the 5-stage RISC-V pipeline.
- Takes the load/store request held in the EX/MEM pipeline register and drives a req/ack data bus.
- Generates byte enables, lane-shifts write data, and extracts/extends read data.
- Stalls the pipeline until the access completes; flags misaligned accesses and bus timeouts.

Parameters:
- WIDTH, 32, data/address width; only 32 is supported (4 byte lanes).
- TIMEOUT, 16, maximum ACCESS cycles without ack before abort; must be >= 2.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset
- mem_read_in  in  1  load request from EX/MEM control vector
- mem_write_in  in  1  store request from EX/MEM control vector
- size_in  in  2  00 byte, 01 half, 10 word; 11 treated as word
- unsigned_in  in  1  1 = zero-extend loads (LBU/LHU)
- addr_in  in  WIDTH  byte address (EX/MEM ALU result)
- wdata_in  in  WIDTH  store data (EX/MEM rs2 data)
- bus_req_out  out  1  bus request
- bus_we_out  out  1  1 = write
- bus_addr_out  out  WIDTH  word-aligned address ({addr[31:2],2'b00})
- bus_be_out  out  4  byte enables
- bus_wdata_out  out  WIDTH  lane-shifted write data
- bus_ack_in  in  1  bus completion, valid only while bus_req_out=1
- bus_rdata_in  in  WIDTH  read data, valid with bus_ack_in
- stall_out  out  1  freeze IF/ID/EX/MEM pipeline registers
- rdata_out  out  WIDTH  extended load result
- rdata_valid_out  out  1  rdata_out valid (one-cycle pulse)
- misalign_out  out  1  misaligned-access exception pulse
- timeout_out  out  1  bus-timeout exception pulse

Behaviour:
- Reset: rst_in is asynchronous, active-low; clock is clk_in. All registered outputs clear to 0 and state = IDLE. A reset mid-access drops bus_req_out immediately; no pulse is generated.
- Request: req = mem_read_in | mem_write_in. If both are set, treat as a write.
- Alignment: aligned = byte, or half with addr[0]=0, or word with addr[1:0]=0.
- FSM IDLE:
  - req & aligned: register addr/we/be/wdata/size/unsigned and go to ACCESS. stall_out=1 combinationally in this cycle.
  - req & !aligned: no bus access, no stall; misalign_out=1 for the next cycle only; stay IDLE.
- FSM ACCESS:
  - bus_req_out=1; all bus outputs stay stable; stall_out=1; cycle counter increments from 0.
  - bus_ack_in: latch read data and go to RESP. Drop bus_req_out at the next edge.
  - Counter reaches TIMEOUT-1 without ack: go to RESP with timeout flag set; rdata_out=0.
  - Ack and timeout in the same cycle: ack wins.
- FSM RESP (1 cycle):
  - stall_out=0; pipeline advances at the end of RESP.
  - Load with ack: rdata_valid_out=1.
  - Timeout: timeout_out=1, rdata_valid_out=0.
  - Store: both pulses 0.
  - Request inputs are ignored in RESP; always return to IDLE.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: 0011 (addr[1]=0) or 1100
  - word: 1111
- Write data: byte replicated to all 4 lanes; half replicated to both halves; word passed through.
- Read data: select lane by registered addr[1:0]; sign- or zero-extend per unsigned. rdata_out holds its value until the next load completes.
- Latency: minimum aligned access is 3 cycles (IDLE issue, ACCESS with ack, RESP); stall high for 2 of them.
- bus_ack_in outside ACCESS is ignored.

Test Plan:
- LW addr=0x100, ack on the 1st ACCESS cycle, rdata=0xDEADBEEF -> be=1111, stall high 2 cycles, RESP rdata_out=0xDEADBEEF with rdata_valid_out=1.
- LB addr=0x103, rdata=0x80xxxxxx -> be=1000, rdata_out=0xFFFFFF80; same access as LBU -> 0x00000080.
- SH addr=0x102, wdata=0x0000ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, bus_addr=0x100; rdata_valid_out stays 0.
- LW addr=0x101 -> no bus_req, stall never high, misalign_out=1 exactly one cycle later.
- SW with ack withheld -> bus_req held exactly 16 cycles (TIMEOUT=16), then timeout_out=1 in RESP; late ack is ignored.
- Reset asserted in the 3rd ACCESS cycle -> bus_req_out and stall_out go 0 asynchronously; next request starts a clean access.
